// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor: diff = (a - b) mod 2^WIDTH, one bit per
//   clock, LSB first, through a single full-subtractor cell and a registered
//   borrow. The calculator control FSM drives it with a start/done handshake.
//
// Ports
//   clk_i     clock, rising edge
//   rst_ni    asynchronous active-low reset
//   start_i   request, sampled only in IDLE
//   a_i/b_i   minuend/subtrahend, captured on the accepted start
//   busy_o    high in RUN and DONE
//   done_o    one-cycle pulse when results become valid
//   diff_o    registered result
//   borrow_o  final borrow out (a < b)
//   zero_o    diff_o == 0
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             zero_o
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic [CNT_W-1:0] cnt;
    logic             br;

    // Full-subtractor cell on the current LSBs.
    logic             d;
    logic             br_next;
    logic [WIDTH-1:0] res_full;

    assign d        = a_sr[0] ^ b_sr[0] ^ br;
    assign br_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    // Result after this bit is shifted in; on the final bit it is complete.
    assign res_full = {d, r_sr[WIDTH-1:1]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            r_sr     <= '0;
            cnt      <= '0;
            br       <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            diff_o   <= '0;
            borrow_o <= 1'b0;
            zero_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        a_sr   <= a_i;
                        b_sr   <= b_i;
                        r_sr   <= '0;
                        cnt    <= '0;
                        br     <= 1'b0;
                        busy_o <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    r_sr <= res_full;
                    br   <= br_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        diff_o   <= res_full;
                        borrow_o <= br_next;
                        zero_o   <= (res_full == '0);
                        done_o   <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
